// File: rtl/ifetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ifetch                                                     |
// | Description : Instruction fetch unit. Issues one word read at a time and |
// |               buffers returned words in a small queue for the decoder.   |
// |               Optional macro IFETCH_BYPASS_EN forwards an acked word     |
// |               straight to the decoder when the queue is empty.           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module ifetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] c_last_ptr  = PW'(DEPTH - 1);
  localparam logic [CW-1:0] c_depth_cnt = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_drain_addr;
  logic [31:0]   r_data [DEPTH];
  logic [31:0]   r_pc   [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_next;
  logic          w_accept;
  logic          w_bypass;
  logic          w_push;
  logic          w_pop;
  logic          w_slot_left;

  function automatic logic [PW-1:0] f_ptr_inc(input logic [PW-1:0] ptr);
    f_ptr_inc = (ptr == c_last_ptr) ? '0 : ptr + 1'b1;
  endfunction

  // A word is accepted only for a live request; redirect and reset kill it.
  assign w_accept = (r_state == S_REQ) && mem_ack && !redirect_valid && !reset;

`ifdef IFETCH_BYPASS_EN
  assign w_bypass = w_accept && (r_count == '0);
`else
  assign w_bypass = 1'b0;
`endif

  assign w_pop  = (r_count != '0) && inst_ready && !redirect_valid;
  assign w_push = w_accept && !(w_bypass && inst_ready);

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + 1'b1;
    end else if (!w_push && w_pop) begin
      w_count_next = r_count - 1'b1;
    end
  end

  assign w_slot_left = (w_count_next < c_depth_cnt);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (redirect_valid || (r_count < c_depth_cnt)) begin
          w_state_next = S_REQ;
        end
      end
      S_REQ: begin
        if (redirect_valid) begin
          w_state_next = mem_ack ? S_REQ : S_DRAIN;
        end else if (mem_ack) begin
          w_state_next = w_slot_left ? S_REQ : S_IDLE;
        end
      end
      S_DRAIN: begin
        if (mem_ack) begin
          w_state_next = S_REQ;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // DRAIN keeps presenting the abandoned address while fetch_pc moves on.
  assign mem_req    = (r_state != S_IDLE);
  assign mem_addr   = (r_state == S_DRAIN) ? r_drain_addr : r_fetch_pc;
  assign inst_valid = (r_count != '0) || w_bypass;
  assign inst       = w_bypass ? mem_rdata : r_data[r_head];
  assign inst_pc    = w_bypass ? mem_addr  : r_pc[r_head];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_fetch_pc   <= RESET_PC;
      r_drain_addr <= RESET_PC;
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
    end else begin
      r_state <= w_state_next;
      if (redirect_valid) begin
        r_fetch_pc <= redirect_pc & ~32'd3;
        r_tail     <= r_head;
        r_count    <= '0;
        if (r_state == S_REQ) begin
          r_drain_addr <= r_fetch_pc;
        end
      end else begin
        if (w_accept) begin
          r_fetch_pc <= r_fetch_pc + 32'd4;
        end
        if (w_push) begin
          r_tail <= f_ptr_inc(r_tail);
        end
        if (w_pop) begin
          r_head <= f_ptr_inc(r_head);
        end
        r_count <= w_count_next;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_data[r_tail] <= mem_rdata;
      r_pc[r_tail]   <= mem_addr;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ifetch.sv
`default_nettype none
// Testbench for ifetch: directed scenarios plus a randomized run against a
// queue-based reference model.
module tb_ifetch;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam int          DEPTH    = 2;
`ifdef IFETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  always #5 clock = ~clock;

  ifetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clock          (clock),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready)
  );

  int checks = 0;
  int errors = 0;

  bit          auto_mem = 1'b0;
  int          lat_cfg  = 0;
  int          cur_lat  = 0;
  int          wcnt     = 0;
  logic [31:0] salt;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
  } word_t;

  // Reference model: word queue, next fetch address, one outstanding request.
  word_t       mq[$];
  logic [31:0] m_fpc;
  logic [31:0] m_addr;
  bit          m_busy;
  bit          m_discard;

  task automatic model_edge();
    int  occ;
    bit  start;
    if (reset) begin
      mq.delete();
      m_fpc     = RESET_PC;
      m_addr    = RESET_PC;
      m_busy    = 1'b0;
      m_discard = 1'b0;
    end else if (redirect_valid) begin
      mq.delete();
      m_fpc = {redirect_pc[31:2], 2'b00};
      if (m_busy && !mem_ack) begin
        m_discard = 1'b1;
      end else begin
        m_busy    = 1'b1;
        m_discard = 1'b0;
        m_addr    = m_fpc;
      end
    end else begin
      occ   = mq.size();
      start = !m_busy && (occ < DEPTH);
      if (occ > 0 && inst_ready) void'(mq.pop_front());
      if (m_busy && mem_ack) begin
        if (m_discard) begin
          m_discard = 1'b0;
          m_addr    = m_fpc;
        end else begin
          if (!(BYP && occ == 0 && inst_ready)) mq.push_back({mem_rdata, m_addr});
          m_fpc = m_fpc + 32'd4;
          if (mq.size() < DEPTH) m_addr = m_fpc;
          else m_busy = 1'b0;
        end
      end
      if (start) begin
        m_busy = 1'b1;
        m_addr = m_fpc;
      end
    end
  endtask

  task automatic drive_mem();
    mem_ack = 1'b0;
    if (mem_req && !reset) begin
      if (wcnt == 0) cur_lat = (lat_cfg < 0) ? int'($urandom_range(0, 3)) : lat_cfg;
      if (wcnt >= cur_lat) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_addr ^ salt;
        wcnt      = 0;
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    if (auto_mem) drive_mem();
  endtask

  task automatic do_reset();
    auto_mem       = 1'b0;
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    inst_ready     = 1'b0;
    mem_ack        = 1'b1;
    mem_rdata      = 32'hBAD0_0000;
    step();
    step();
    reset   = 1'b0;
    mem_ack = 1'b0;
    wcnt    = 0;
  endtask

  task automatic test_reset();
    bit seen;
    do_reset();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", mem_req); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", inst_valid); end
    checks++; if (mem_addr !== RESET_PC) begin errors++; $display("FAIL reset_addr got %h want %h", mem_addr, RESET_PC); end
    step();
    step();
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL reset_first_req got %b want 1", mem_req); end
    // Reset mid-request with an ack in the same cycle: nothing may be queued.
    reset   = 1'b1;
    mem_ack = 1'b1;
    step();
    reset   = 1'b0;
    mem_ack = 1'b0;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_abandon_req got %b want 0", mem_req); end
    step();
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_ack_ignored got %b want 0", inst_valid); end
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      if (mem_req) seen = 1'b1;
      else step();
    end
    checks++;
    if (!seen || mem_addr !== RESET_PC) begin
      errors++; $display("FAIL reset_restart_addr got %h req %b want %h", mem_addr, mem_req, RESET_PC);
    end
  endtask

  task automatic test_zero_wait();
    bit found;
    do_reset();
    lat_cfg    = 0;
    auto_mem   = 1'b1;
    inst_ready = 1'b1;
    found      = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (inst_valid) found = 1'b1;
      else step();
    end
    checks++; if (!found) begin errors++; $display("FAIL zw_fill got no inst_valid want 1 within 10 cycles"); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== RESET_PC + 32'(4 * k) || inst !== ((RESET_PC + 32'(4 * k)) ^ salt)) begin
        errors++;
        $display("FAIL zw_seq%0d got v=%b pc=%h inst=%h want pc=%h", k, inst_valid, inst_pc, inst, RESET_PC + 32'(4 * k));
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    int acks;
    do_reset();
    lat_cfg  = 0;
    auto_mem = 1'b1;
    acks     = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (mem_ack) acks++;
    end
    checks++; if (acks !== 2) begin errors++; $display("FAIL bp_acks got %0d want 2", acks); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL bp_req_idle got %b want 0", mem_req); end
    checks++; if (inst_valid !== 1'b1 || inst_pc !== RESET_PC) begin errors++; $display("FAIL bp_head got v=%b pc=%h want %h", inst_valid, inst_pc, RESET_PC); end
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    acks = 0;
    if (mem_ack) acks++;
    for (int i = 0; i < 6; i++) begin
      step();
      if (mem_ack) acks++;
    end
    checks++; if (acks !== 1) begin errors++; $display("FAIL bp_refill got %0d want 1", acks); end
    checks++; if (inst_pc !== RESET_PC + 32'd4) begin errors++; $display("FAIL bp_next_head got %h want %h", inst_pc, RESET_PC + 32'd4); end
  endtask

  task automatic test_slow_ack();
    logic [31:0] a;
    do_reset();
    lat_cfg  = 3;
    auto_mem = 1'b1;
    step();
    a = mem_addr;
    checks++; if (a !== RESET_PC) begin errors++; $display("FAIL slow_addr got %h want %h", a, RESET_PC); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== a || mem_ack !== 1'b0 || inst_valid !== 1'b0) begin
        errors++; $display("FAIL slow_hold%0d got req=%b addr=%h v=%b want 1 %h 0", k, mem_req, mem_addr, inst_valid, a);
      end
      step();
    end
    checks++; if (mem_ack !== 1'b1 || mem_addr !== a) begin errors++; $display("FAIL slow_ack got ack=%b addr=%h want 1 %h", mem_ack, mem_addr, a); end
    step();
    checks++; if (inst_valid !== 1'b1 || inst_pc !== a || mem_addr !== a + 32'd4) begin
      errors++; $display("FAIL slow_push got v=%b pc=%h next=%h want pc=%h", inst_valid, inst_pc, mem_addr, a);
    end
  endtask

  task automatic test_redirect_drain();
    bit found;
    do_reset();
    inst_ready = 1'b1;
    found      = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (mem_req && mem_addr == 32'h8000_0010) begin
        found = 1'b1;
      end else begin
        mem_ack   = mem_req;
        mem_rdata = mem_addr ^ salt;
        step();
      end
    end
    checks++; if (!found) begin errors++; $display("FAIL drain_reach got %h want 80000010", mem_addr); end
    mem_ack        = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0102;
    step();
    redirect_valid = 1'b0;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h8000_0010 || inst_valid !== 1'b0) begin
      errors++; $display("FAIL drain_hold got req=%b addr=%h v=%b want 1 80000010 0", mem_req, mem_addr, inst_valid);
    end
    step();
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    step();
    mem_ack = 1'b0;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h8000_0100 || inst_valid !== 1'b0) begin
      errors++; $display("FAIL drain_restart got req=%b addr=%h v=%b want 1 80000100 0", mem_req, mem_addr, inst_valid);
    end
    step();
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got %b want 0", inst_valid); end
    mem_ack   = 1'b1;
    mem_rdata = 32'h1234_0001;
    step();
    mem_ack = 1'b0;
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h8000_0100 || inst !== 32'h1234_0001) begin
      errors++; $display("FAIL drain_word got v=%b pc=%h inst=%h want 80000100 12340001", inst_valid, inst_pc, inst);
    end
  endtask

  task automatic test_redirect_ack();
    do_reset();
    lat_cfg    = 0;
    auto_mem   = 1'b1;
    inst_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    auto_mem = 1'b0;
    checks++; if (mem_ack !== 1'b1 || inst_valid !== 1'b1) begin errors++; $display("FAIL rack_pre got ack=%b v=%b want 1 1", mem_ack, inst_valid); end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_4000;
    step();
    redirect_valid = 1'b0;
    mem_ack        = 1'b0;
    #1;
    checks++; if (inst_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h0000_4000) begin
      errors++; $display("FAIL rack_post got v=%b req=%b addr=%h want 0 1 00004000", inst_valid, mem_req, mem_addr);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFE;
    step();
    redirect_valid = 1'b0;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr got %h want fffffffc", mem_addr); end
    mem_ack   = 1'b1;
    mem_rdata = 32'h1234_5678;
    #1;
    checks++; if (inst_valid !== BYP) begin errors++; $display("FAIL same_cycle_valid got %b want %b", inst_valid, BYP); end
`ifdef IFETCH_BYPASS_EN
    checks++; if (inst !== 32'h1234_5678 || inst_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL bypass_word got %h/%h want 12345678/fffffffc", inst, inst_pc); end
`endif
    step();
    mem_ack = 1'b0;
    checks++; if (mem_addr !== 32'h0000_0000 || inst_valid !== 1'b1 || inst_pc !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_next got addr=%h v=%b pc=%h want 00000000 1 fffffffc", mem_addr, inst_valid, inst_pc);
    end
  endtask

  task automatic test_random();
    bit          ev;
    word_t       eh;
    logic [31:0] ea;
    do_reset();
    lat_cfg  = -1;
    auto_mem = 1'b1;
    for (int c = 0; c < 600; c++) begin
      inst_ready     = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = $urandom;
      @(negedge clock);
      ev = (mq.size() > 0) || (BYP && m_busy && !m_discard && mem_ack && !redirect_valid);
      eh = (mq.size() > 0) ? mq[0] : {mem_rdata, m_addr};
      ea = m_busy ? m_addr : m_fpc;
      checks++; if (mem_req !== m_busy) begin errors++; $display("FAIL rnd_req c=%0d got %b want %b", c, mem_req, m_busy); end
      checks++; if (mem_addr !== ea) begin errors++; $display("FAIL rnd_addr c=%0d got %h want %h", c, mem_addr, ea); end
      checks++; if (inst_valid !== ev) begin errors++; $display("FAIL rnd_valid c=%0d got %b want %b", c, inst_valid, ev); end
      if (ev) begin
        checks++;
        if (inst !== eh.data || inst_pc !== eh.pc) begin
          errors++; $display("FAIL rnd_head c=%0d got %h/%h want %h/%h", c, inst, inst_pc, eh.data, eh.pc);
        end
      end
      step();
    end
    redirect_valid = 1'b0;
  endtask

  initial begin
    salt           = $urandom;
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    mem_ack        = 1'b0;
    mem_rdata      = 32'h0;
    inst_ready     = 1'b0;
    test_reset();
    test_zero_wait();
    test_backpressure();
    test_slow_ack();
    test_redirect_drain();
    test_redirect_ack();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
